// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: opcode enum, flag bit positions and
// the stored result record (sign-magnitude value, two's-complement value, flags).
package alu_pkg;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned RES_W  = 2 * DATA_W;
  localparam int unsigned FLAG_W = 4;

  // Bit positions inside the flags word {E,V,Nf,Z}
  localparam int unsigned FLAG_Z  = 0;
  localparam int unsigned FLAG_NF = 1;
  localparam int unsigned FLAG_V  = 2;
  localparam int unsigned FLAG_E  = 3;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    MOD = 3'd4
  } op_e;

  typedef struct packed {
    logic [DATA_W-1:0] res_sm;
    logic [RES_W-1:0]  res_tc;
    logic [FLAG_W-1:0] flags;
  } result_t;

endpackage

// File: rtl/result_flags.sv
// Combinational result select and status flag generation.
// Ports: op (opcode), divisor (B operand, zero detect only), raw two's-complement
// results *_tc, sign-magnitude results *_sm, result_c (selected record).
module result_flags
  import alu_pkg::*;
#(
  parameter int unsigned N = DATA_W
) (
  input  logic [2:0]     op,
  input  logic [N-1:0]   divisor,
  input  logic [N:0]     sum_tc,
  input  logic [N:0]     sub_tc,
  input  logic [2*N-1:0] mul_tc,
  input  logic [N:0]     div_tc,
  input  logic [N:0]     mod_tc,
  input  logic [N-1:0]   sum_sm,
  input  logic [N-1:0]   sub_sm,
  input  logic [2*N-1:0] mul_sm,
  input  logic [N-1:0]   div_sm,
  input  logic [N-1:0]   mod_sm,
  output result_t        result_c
);

  // Largest magnitude a sign-magnitude N-bit word can hold
  localparam logic signed [2*N-1:0] SM_HI = (2*N)'(2**(N-1) - 1);
  localparam logic signed [2*N-1:0] SM_LO = -SM_HI;

  logic [2*N-1:0] tc;
  logic [N-1:0]   sm;
  logic           illegal;
  logic           div_zero;
  logic           err;

  // Sign bit of the divisor and the upper product bits play no part here
  logic unused_bits;
  assign unused_bits = ^{divisor[N-1], mul_sm[2*N-1:N]};

  // Opcode select; N+1-bit results are sign-extended to 2N
  always_comb begin
    tc      = '0;
    sm      = '0;
    illegal = 1'b0;
    case (op_e'(op))
      ADD: begin tc = {{(N-1){sum_tc[N]}}, sum_tc}; sm = sum_sm; end
      SUB: begin tc = {{(N-1){sub_tc[N]}}, sub_tc}; sm = sub_sm; end
      MUL: begin tc = mul_tc;                       sm = mul_sm[N-1:0]; end
      DIV: begin tc = {{(N-1){div_tc[N]}}, div_tc}; sm = div_sm; end
      MOD: begin tc = {{(N-1){mod_tc[N]}}, mod_tc}; sm = mod_sm; end
      default: illegal = 1'b1;
    endcase
  end

  // +0 and -0 divisors are both a divide-by-zero
  assign div_zero = ((op == DIV) || (op == MOD)) && (divisor[N-2:0] == '0);
  assign err      = illegal || div_zero;

  // Error forces a clean zero result; otherwise flags come from the 2N-bit value
  always_comb begin
    result_c = '0;
    if (err) begin
      result_c.flags[FLAG_E] = 1'b1;
      result_c.flags[FLAG_Z] = 1'b1;
    end else begin
      result_c.res_sm         = sm;
      result_c.res_tc         = tc;
      result_c.flags[FLAG_Z]  = (tc == '0);
      result_c.flags[FLAG_NF] = tc[2*N-1];
      result_c.flags[FLAG_V]  = ($signed(tc) > SM_HI) || ($signed(tc) < SM_LO);
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage: selects/flags the arithmetic result, buffers it in a
// 2-entry skid FIFO with valid/ready on both sides, and keeps saturating counters.
// Ports: clk, rst (async active-low), in_valid/in_ready, op, B, raw *_tc and *_sm
// results, out_valid/out_ready, res_sm, res_tc, flags {E,V,Nf,Z}, op_cnt, err_cnt.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned N     = DATA_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [N-1:0]     B,
  input  logic [N:0]       sum_tc,
  input  logic [N:0]       sub_tc,
  input  logic [2*N-1:0]   mul_tc,
  input  logic [N:0]       div_tc,
  input  logic [N:0]       mod_tc,
  input  logic [N-1:0]     sum_sm,
  input  logic [N-1:0]     sub_sm,
  input  logic [N-1:0]     div_sm,
  input  logic [N-1:0]     mod_sm,
  input  logic [2*N-1:0]   mul_sm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     res_sm,
  output logic [2*N-1:0]   res_tc,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Encoding chosen so bit 0 is "has data" and bit 1 is "full"
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e  state, state_next;
  result_t cur;
  result_t head, skid;
  logic    push, pop;
  logic    load_head, head_from_skid, load_skid;

  result_flags #(.N(N)) u_result_flags (
    .op      (op),
    .divisor (B),
    .sum_tc  (sum_tc),
    .sub_tc  (sub_tc),
    .mul_tc  (mul_tc),
    .div_tc  (div_tc),
    .mod_tc  (mod_tc),
    .sum_sm  (sum_sm),
    .sub_sm  (sub_sm),
    .mul_sm  (mul_sm),
    .div_sm  (div_sm),
    .mod_sm  (mod_sm),
    .result_c(cur)
  );

  // Handshakes depend on registered state only
  assign out_valid = state[0];
  assign in_ready  = ~state[1];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_next;
  end

  // Next state and entry-load controls
  always_comb begin
    state_next     = state;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          load_head  = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head  = 1'b1;
        end else if (push) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next     = ONE;
          load_head      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Head entry drives the outputs directly; skid holds the second entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head) head <= head_from_skid ? skid : cur;
      if (load_skid) skid <= cur;
    end
  end

  assign res_sm = head.res_sm;
  assign res_tc = head.res_tc;
  assign flags  = head.flags;

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (push) begin
      if (op_cnt != '1) op_cnt <= op_cnt + CNT_W'(1);
      if (cur.flags[FLAG_E] && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected records are built from an
// integer value per push and compared in order at the output handshake.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int unsigned N     = 6;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [2:0]       op;
  logic [N-1:0]     B;
  logic [N:0]       sum_tc, sub_tc, div_tc, mod_tc;
  logic [2*N-1:0]   mul_tc, mul_sm;
  logic [N-1:0]     sum_sm, sub_sm, div_sm, mod_sm;
  logic             out_valid, out_ready;
  logic [N-1:0]     res_sm;
  logic [2*N-1:0]   res_tc;
  logic [3:0]       flags;
  logic [CNT_W-1:0] op_cnt, err_cnt;

  int        n_tests = 0;
  int        n_fail  = 0;
  result_t   sb[$];
  int        exp_op  = 0;
  int        exp_err = 0;
  bit        rand_done;

  alu_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .B(B),
    .sum_tc(sum_tc), .sub_tc(sub_tc), .mul_tc(mul_tc), .div_tc(div_tc), .mod_tc(mod_tc),
    .sum_sm(sum_sm), .sub_sm(sub_sm), .div_sm(div_sm), .mod_sm(mod_sm), .mul_sm(mul_sm),
    .out_valid(out_valid), .out_ready(out_ready), .res_sm(res_sm), .res_tc(res_tc),
    .flags(flags), .op_cnt(op_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output monitor: head must match scoreboard front every valid cycle
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        check("res_sm", 64'(res_sm), 64'(sb[0].res_sm));
        check("res_tc", 64'(res_tc), 64'(sb[0].res_tc));
        check("flags",  64'(flags),  64'(sb[0].flags));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Drive one operation whose selected result is the integer v; waits for accept
  task automatic push_op(input logic [2:0] o, input logic [N-1:0] b, input int v);
    result_t        e;
    logic [N-1:0]   sm;
    logic [N:0]     t7;
    logic [2*N-1:0] t12;
    bit             err;
    int             guard;
    sum_tc = 7'($urandom); sub_tc = 7'($urandom); div_tc = 7'($urandom); mod_tc = 7'($urandom);
    sum_sm = 6'($urandom); sub_sm = 6'($urandom); div_sm = 6'($urandom); mod_sm = 6'($urandom);
    mul_tc = 12'($urandom); mul_sm = 12'($urandom);
    op = o;
    B  = b;
    sm  = {(v < 0), 5'((v < 0) ? -v : v)};
    t7  = 7'(v);
    t12 = 12'(v);
    case (o)
      3'd0: begin sum_tc = t7; sum_sm = sm; end
      3'd1: begin sub_tc = t7; sub_sm = sm; end
      3'd2: begin mul_tc = t12; mul_sm = {6'($urandom), sm}; end
      3'd3: begin div_tc = t7; div_sm = sm; end
      3'd4: begin mod_tc = t7; mod_sm = sm; end
      default: ;
    endcase
    err = (o > 3'd4) || (((o == 3'd3) || (o == 3'd4)) && (b[4:0] == 5'd0));
    e.res_sm = err ? 6'd0 : sm;
    e.res_tc = err ? 12'd0 : t12;
    e.flags  = err ? 4'b1001 : {1'b0, ((v > 31) || (v < -31)), (v < 0), (v == 0)};
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      check("push_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    if (exp_op < 255) exp_op++;
    if (err && exp_err < 255) exp_err++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_op_cnt"},  64'(op_cnt),  64'(exp_op));
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; B = 6'd1;
    sum_tc = '0; sub_tc = '0; div_tc = '0; mod_tc = '0; mul_tc = '0;
    sum_sm = '0; sub_sm = '0; div_sm = '0; mod_sm = '0; mul_sm = '0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res_tc",    64'(res_tc),    64'd0);
    check("rst_flags",     64'(flags),     64'd0);
    check("rst_op_cnt",    64'(op_cnt),    64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // 1: simple add, one-cycle latency
    push_op(3'd0, 6'd1, 2);
    check("t1_out_valid", 64'(out_valid), 64'd1);
    drain();

    // 2: overflow and negative product, sign-magnitude boundaries
    push_op(3'd0, 6'd1, 40);
    push_op(3'd2, 6'd1, -35);
    push_op(3'd1, 6'd1, 31);
    push_op(3'd1, 6'd1, -31);
    push_op(3'd0, 6'd1, 32);
    push_op(3'd4, 6'd3, -32);
    push_op(3'd0, 6'd1, 0);
    drain();

    // 3: divide by -0 / +0 and illegal opcodes
    push_op(3'd3, 6'b100000, 5);
    check_counters("t3a");
    push_op(3'd6, 6'd1, 7);
    check_counters("t3b");
    push_op(3'd4, 6'b000000, -3);
    push_op(3'd7, 6'd2, 1);
    push_op(3'd3, 6'b100001, -9);
    drain();
    check_counters("t3c");

    // 4: fill with stalled output, third push waits for space
    out_ready = 1'b0;
    push_op(3'd0, 6'd1, 1);
    check("t4_ready_one", 64'(in_ready), 64'd1);
    push_op(3'd0, 6'd1, 2);
    check("t4_ready_full", 64'(in_ready), 64'd0);
    fork
      push_op(3'd0, 6'd1, 3);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check_counters("t4");

    // 5: stalled head stays stable (monitor compares every cycle)
    out_ready = 1'b0;
    push_op(3'd2, 6'd1, -100);
    repeat (5) begin
      @(posedge clk); #1;
      check("t5_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    drain();

    // Random mix with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [2:0] ro;
          int rv;
          ro = 3'($urandom_range(0, 7));
          rv = (ro == 3'd2) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 127)) - 64;
          push_op(ro, 6'($urandom), rv);
        end
        rand_done = 1'b1;
      end
      begin
        for (int k = 0; k < 3000 && !rand_done; k++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check_counters("rand");

    // 6: async reset with two entries buffered
    out_ready = 1'b0;
    push_op(3'd0, 6'd1, 5);
    push_op(3'd0, 6'd1, 6);
    #3 rst_n = 1'b0;
    #1;
    sb.delete();
    exp_op = 0;
    exp_err = 0;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check_counters("t6");
    check("t6_res_tc", 64'(res_tc), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t6_in_ready", 64'(in_ready), 64'd1);
    repeat (4) begin
      @(posedge clk); #1;
      check("t6_no_stale", 64'(out_valid), 64'd0);
    end
    push_op(3'd1, 6'd1, -7);
    drain();
    check_counters("t6_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
